pool_writer: RTL
================

Name: pool_writer

Overview:
- Sits directly downstream of addr_controller and the conv MAC array. Consumes the valid conv-result stream.
- In pooling modes: applies optional ReLU, then 2x2 stride-2 max-pooling using a single line buffer. Emits pooled values with their feature-map write address.
- In non-pooling modes: passes results through to addr_controller's write address unchanged.
- Output drives the write port of the next feature-map buffer.

Parameters:
- DATA_WIDTH, 16, signed conv result width.
- ADDR_WIDTH, 11, feature-map buffer address width.
- MAX_LINE, 14, maximum pooled row width (line buffer depth).
- POOL_A_IN_SIZE, 28, conv output width for mode 3'b000 (conv1 -> 14x14).
- POOL_A_OUT_BASE, 0, write base address for pooled map A.
- POOL_B_IN_SIZE, 10, conv output width for mode 3'b010 (conv2 -> 5x5).
- POOL_B_OUT_BASE, 0, write base address for pooled map B.
- RELU_EN, 1, 1 = clamp negatives to 0 before pooling/bypass.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- ctrl_mode  in  3  layer mode (same encoding as addr_controller).
- in_valid  in  1  conv result valid (from addr_controller valid_out, latency-aligned).
- in_data  in  DATA_WIDTH  signed conv result.
- in_addr  in  ADDR_WIDTH  write address from addr_controller (used in bypass only).
- out_valid  out  1  write strobe.
- out_data  out  DATA_WIDTH  pooled / bypassed value.
- out_addr  out  ADDR_WIDTH  write address.
- frame_done  out  1  one-cycle pulse with last output of a frame.
- row_out  out  ADDR_WIDTH  debug: input row counter.
- col_out  out  ADDR_WIDTH  debug: input column counter.

Behaviour:
- Reset (rst=1 at posedge): out_valid, out_data, out_addr, frame_done, row/col counters, h_reg and mode_q all 0. Line buffer contents are don't-care (always written before read).
- Mode decode:
  - 000 -> pool, S=POOL_A_IN_SIZE, base=POOL_A_OUT_BASE.
  - 010 -> pool, S=POOL_B_IN_SIZE, base=POOL_B_OUT_BASE.
  - All others -> BYPASS.
  - S must be even and S/2 <= MAX_LINE.
- ReLU: v = (RELU_EN && in_data<0) ? 0 : in_data. Comparisons are signed.
- States: IDLE_ROW (r even) / ODD_ROW (r odd), derived from row counter LSB. Samples are row-major.
- Pool datapath, only on cycles with in_valid=1:
  - c even: h_reg <= v.
  - c odd: hmax = max(h_reg, v).
  - r even: line_buf[c>>1] <= hmax, no output.
  - r odd: out_data <= max(line_buf[c>>1], hmax); out_addr <= base + (r>>1)*(S/2) + (c>>1); out_valid <= 1.
  - Counters: c++; at c=S-1, c<=0 and r++; at (S-1,S-1), r<=0, c<=0 and frame_done <= 1 together with the final out_valid.
- in_valid=0: counters, h_reg and line buffer hold; out_valid and frame_done deassert next cycle. Bubbles are allowed anywhere.
- Bypass: out_valid <= in_valid; out_data <= v; out_addr <= in_addr; frame_done stays 0; counters held at 0.
- Latency: exactly 1 cycle from the qualifying input edge to out_valid in both pool and bypass.
- Address arithmetic: computed in ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH. Overflow is a configuration error; the block does not detect it.
- Mode change: mode_q registers ctrl_mode. On any cycle where ctrl_mode != mode_q, counters and h_reg clear. A sample arriving in that same cycle is treated as (0,0) of the new frame. The partial previous frame is discarded and produces no outputs and no frame_done.
- Back-to-back frames: the sample following frame_done is (0,0). No idle cycle is required.
- Reset mid-frame: outputs 0 on the next cycle and the counters restart at (0,0).

Decomposition:
- Package lenet_pool_pkg holds:
  - mode encodings (MODE_POOL_A=3'b000, MODE_POOL_B=3'b010);
  - the size/base defaults;
  - a signed max function.
- One sub-module, pool_line_buffer: MAX_LINE x DATA_WIDTH distributed RAM with one synchronous write and one asynchronous read, instantiated once.

Test Plan:
- Mode 000, 784 gapless samples with in_data=r*28+c -> 196 outputs, out_data=(2pr+1)*28+2pc+1, out_addr=0..195 in order, frame_done only with out_addr=195.
- Mode 010, RELU_EN=1, in_data=-(r*10+c) for even r and +(r*10+c) for odd r -> 25 outputs, out_data=(2pr+1)*10+2pc+1. Repeat with all samples negative -> 25 outputs of 0.
- Mode 001 bypass, in_valid=1, in_addr=37, in_data=-5 -> next cycle out_valid=1, out_addr=37, out_data=0. With in_data=9 -> out_data=9. frame_done stays 0.
- Mode 000 ramp with random 0-3 cycle bubbles on in_valid -> output sequence identical to the gapless run, each output exactly 1 cycle after its qualifying sample.
- Mode 000 for 50 samples, then switch to 010 and run a full frame -> no outputs from the partial frame; 25 correct mode-010 outputs, first at out_addr=POOL_B_OUT_BASE.
- rst=1 for 1 cycle at sample 300 of a mode-000 frame -> all outputs 0 next cycle. The following full frame yields the exact 196-output sequence of the gapless run.

Source files
------------

// File: rtl/lenet_pool_pkg.sv
// Shared definitions for the LeNet pooling writer.
// Mode encodings, default geometry and a signed max helper.
package lenet_pool_pkg;

   localparam logic [2:0] MODE_POOL_A = 3'b000;
   localparam logic [2:0] MODE_POOL_B = 3'b010;

   localparam int DEF_DATA_WIDTH      = 16;
   localparam int DEF_ADDR_WIDTH      = 11;
   localparam int DEF_MAX_LINE        = 14;
   localparam int DEF_POOL_A_IN_SIZE  = 28;
   localparam int DEF_POOL_A_OUT_BASE = 0;
   localparam int DEF_POOL_B_IN_SIZE  = 10;
   localparam int DEF_POOL_B_OUT_BASE = 0;
   localparam int DEF_RELU_EN         = 1;

   typedef enum logic [1:0] {
      SEL_BYPASS,
      SEL_A,
      SEL_B
   } pool_sel_e;

   typedef enum logic {
      IDLE_ROW,
      ODD_ROW
   } row_state_e;

   function automatic pool_sel_e decode_mode(input logic [2:0] mode);
      pool_sel_e sel;
      sel = SEL_BYPASS;
      unique case (1'b1)
         (mode == MODE_POOL_A): sel = SEL_A;
         (mode == MODE_POOL_B): sel = SEL_B;
         default:               sel = SEL_BYPASS;
      endcase
      return sel;
   endfunction

   // Operands are sign-extended to 32 bits, so any DATA_WIDTH <= 32 works.
   function automatic logic signed [31:0] smax(
      input logic signed [31:0] a,
      input logic signed [31:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer for 2x2 pooling.
// Synchronous write port, asynchronous read port, no reset on storage.
module pool_line_buffer #(
   parameter int DEPTH = 14,
   parameter int WIDTH = 16,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pool_writer.sv
// ReLU + 2x2/2 max-pool writer for conv results, with a bypass path
// that forwards addr_controller's write address unchanged.
module pool_writer
   import lenet_pool_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int MAX_LINE        = DEF_MAX_LINE,
   parameter int POOL_A_IN_SIZE  = DEF_POOL_A_IN_SIZE,
   parameter int POOL_A_OUT_BASE = DEF_POOL_A_OUT_BASE,
   parameter int POOL_B_IN_SIZE  = DEF_POOL_B_IN_SIZE,
   parameter int POOL_B_OUT_BASE = DEF_POOL_B_OUT_BASE,
   parameter int RELU_EN         = DEF_RELU_EN
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2:0]                   ctrl_mode,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0]        in_addr,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0]        out_addr,
   output logic                         frame_done,
   output logic [ADDR_WIDTH-1:0]        row_out,
   output logic [ADDR_WIDTH-1:0]        col_out
);

   localparam int LB_AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   logic [2:0]                   mode_q, mode_d;
   logic [ADDR_WIDTH-1:0]        row_q, row_d;
   logic [ADDR_WIDTH-1:0]        col_q, col_d;
   logic signed [DATA_WIDTH-1:0] h_q, h_d;
   logic                         out_valid_q, out_valid_d;
   logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [ADDR_WIDTH-1:0]        out_addr_q, out_addr_d;
   logic                         frame_done_q, frame_done_d;

   pool_sel_e                    sel;
   row_state_e                   row_st;
   logic                         is_pool;
   logic                         mode_chg;
   logic [ADDR_WIDTH-1:0]        size_w;
   logic [ADDR_WIDTH-1:0]        half_w;
   logic [ADDR_WIDTH-1:0]        last_w;
   logic [ADDR_WIDTH-1:0]        base_w;
   logic [ADDR_WIDTH-1:0]        r_cur;
   logic [ADDR_WIDTH-1:0]        c_cur;
   logic signed [DATA_WIDTH-1:0] h_cur;
   logic signed [DATA_WIDTH-1:0] v;
   logic signed [DATA_WIDTH-1:0] hmax;
   logic signed [DATA_WIDTH-1:0] pooled;
   logic [ADDR_WIDTH-1:0]        pool_addr;

   logic                         lb_we;
   logic [LB_AW-1:0]             lb_idx;
   logic [DATA_WIDTH-1:0]        lb_wdata;
   logic [DATA_WIDTH-1:0]        lb_rdata;

   pool_line_buffer #(
      .DEPTH (MAX_LINE),
      .WIDTH (DATA_WIDTH),
      .AW    (LB_AW)
   ) u_line_buf (
      .clk   (clk),
      .we    (lb_we),
      .waddr (lb_idx),
      .wdata (lb_wdata),
      .raddr (lb_idx),
      .rdata (lb_rdata)
   );

   // Geometry and the effective position of the incoming sample.
   // A mode change restarts the frame on this very sample.
   always_comb begin
      sel      = decode_mode(ctrl_mode);
      is_pool  = (sel != SEL_BYPASS);
      mode_chg = (ctrl_mode != mode_q);

      size_w = (sel == SEL_B) ? ADDR_WIDTH'(POOL_B_IN_SIZE)
                              : ADDR_WIDTH'(POOL_A_IN_SIZE);
      base_w = (sel == SEL_B) ? ADDR_WIDTH'(POOL_B_OUT_BASE)
                              : ADDR_WIDTH'(POOL_A_OUT_BASE);
      half_w = size_w >> 1;
      last_w = size_w - ONE;

      r_cur  = mode_chg ? '0 : row_q;
      c_cur  = mode_chg ? '0 : col_q;
      h_cur  = mode_chg ? '0 : h_q;
      row_st = row_state_e'(r_cur[0]);

      v = ((RELU_EN != 0) && in_data[DATA_WIDTH-1]) ? '0 : in_data;

      hmax   = DATA_WIDTH'(smax(32'(h_cur), 32'(v)));
      lb_idx = LB_AW'(c_cur >> 1);
      pooled = DATA_WIDTH'(smax(32'(signed'(lb_rdata)), 32'(hmax)));

      pool_addr = base_w + ((r_cur >> 1) * half_w) + (c_cur >> 1);
   end

   always_comb begin
      mode_d       = ctrl_mode;
      row_d        = r_cur;
      col_d        = c_cur;
      h_d          = h_cur;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      out_addr_d   = out_addr_q;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;
      lb_wdata     = hmax;

      if (!is_pool) begin
         row_d       = '0;
         col_d       = '0;
         h_d         = '0;
         out_valid_d = in_valid;
         out_data_d  = v;
         out_addr_d  = in_addr;
      end else if (in_valid) begin
         if (!c_cur[0]) begin
            h_d = v;
         end else begin
            unique case (row_st)
               IDLE_ROW: lb_we = 1'b1;
               ODD_ROW: begin
                  out_valid_d  = 1'b1;
                  out_data_d   = pooled;
                  out_addr_d   = pool_addr;
                  frame_done_d = (r_cur == last_w) && (c_cur == last_w);
               end
            endcase
         end

         if (c_cur == last_w) begin
            col_d = '0;
            row_d = (r_cur == last_w) ? '0 : r_cur + ONE;
         end else begin
            col_d = c_cur + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= '0;
         row_q        <= '0;
         col_q        <= '0;
         h_q          <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_addr_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         row_q        <= row_d;
         col_q        <= col_d;
         h_q          <= h_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_addr_q   <= out_addr_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_addr   = out_addr_q;
   assign frame_done = frame_done_q;
   assign row_out    = row_q;
   assign col_out    = col_q;

endmodule
